branch_resolve_ctrl: RTL and testbench

Controller that sits between the execute stage and the branch predictor. It compares each resolved branch against the prediction carried down the pipe and, on a mispredict, issues a one-cycle fetch redirect and a multi-cycle fetch/decode flush. Every non-squashed resolution is serialized through a small update queue onto the predictor's single table write port using a valid/ready handshake. It also keeps branch and mispredict statistics.

---
 rtl/branch_resolve_ctrl_pkg.sv | 15 +
 rtl/branch_update_fifo.sv | 72 +++++++
 rtl/branch_resolve_ctrl.sv | 179 +++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolve controller: FSM state
// encodings and default sizing values used by the top and the update FIFO.
package branch_resolve_ctrl_pkg;

  localparam int WORD_SIZE_DEF    = 32;
  localparam int QDEPTH_DEF       = 4;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int CNT_W_DEF        = 16;

  typedef enum logic [0:0] {
    BRC_IDLE  = 1'b0,
    BRC_FLUSH = 1'b1
  } brc_state_e;

endpackage

// File: rtl/branch_update_fifo.sv
// Synchronous FIFO that serializes predictor updates onto the single table
// write port. A push into a full FIFO is accepted only when a pop happens in
// the same cycle; otherwise it is rejected and the caller counts the drop.
// The almost-full flag is registered so it never depends on this cycle's
// push/pop inputs.
module branch_update_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - 1);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [AW:0]      occ_d;
  logic             af_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty       = (wr_q == rd_q);
  assign full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout        = mem_q[rd_q[AW-1:0]];
  assign almost_full = af_q;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Advance the pointers and work out the occupancy after this cycle's moves.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    occ_d = wr_d - rd_d;
  end

  // Pointer, storage and almost-full registers; reset discards all entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      af_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      af_q <= (occ_d >= AF_LEVEL);
      if (push_ok) begin
        mem_q[wr_q[AW-1:0]] <= din;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: checks each resolved branch against the
// prediction carried down the pipe, redirects fetch and flushes fetch/decode
// on a mispredict, queues predictor updates and keeps saturating statistics.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int QDEPTH       = QDEPTH_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [WORD_SIZE-1:0] ex_pc,
  input  logic                 ex_taken,
  input  logic [WORD_SIZE-1:0] ex_target,
  input  logic [WORD_SIZE-1:0] ex_pcplus4,
  input  logic                 ex_pred_taken,
  input  logic [WORD_SIZE-1:0] ex_pred_target,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 flush_fd,
  output logic                 stall_pipe,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic [WORD_SIZE-1:0] upd_pc,
  output logic [WORD_SIZE-1:0] upd_target,
  output logic                 upd_taken,
  output logic [CNT_W-1:0]     branch_cnt,
  output logic [CNT_W-1:0]     mispredict_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int FCW   = $clog2(FLUSH_CYCLES + 1);
  localparam int QW    = 2 * WORD_SIZE + 1;

  brc_state_e state_q, state_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  logic                 redirect_valid_q, redirect_valid_d;
  logic [WORD_SIZE-1:0] redirect_pc_q, redirect_pc_d;
  logic                 flush_q, flush_d;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic          mispredict;
  logic          accept;
  logic          deq;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_af;
  logic [QW-1:0] fifo_din;
  logic [QW-1:0] fifo_dout;

  // A branch is mispredicted on a wrong direction, or on a correctly
  // predicted taken branch whose predicted target was stale.
  assign mispredict = (ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));

  // Resolutions arriving while flushing are wrong-path and simply ignored.
  assign accept = ex_valid && (state_q == BRC_IDLE);
  assign deq    = !fifo_empty && upd_ready;
  assign drop   = accept && fifo_full && !deq;

  assign fifo_din = {ex_pc, ex_target, ex_taken};

  branch_update_fifo #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (accept),
    .din         (fifo_din),
    .full        (fifo_full),
    .pop         (deq),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .almost_full (fifo_af)
  );

  assign upd_valid                        = !fifo_empty;
  assign {upd_pc, upd_target, upd_taken}  = fifo_dout;
  assign stall_pipe                       = fifo_af;

  // FSM state register together with the flush down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BRC_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state: enter FLUSH on an accepted mispredict and leave after the
  // last flush cycle, when the counter is about to run out.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      BRC_IDLE: begin
        if (accept && mispredict) begin
          state_d = BRC_FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES);
        end
      end
      BRC_FLUSH: begin
        fcnt_d = fcnt_q - 1'b1;
        if (fcnt_q == FCW'(1)) begin
          state_d = BRC_IDLE;
        end
      end
      default: begin
        state_d = BRC_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Next values of the registered FSM outputs; the redirect PC is held
  // between mispredicts so the fetch stage always sees a stable value.
  always_comb begin
    redirect_valid_d = accept && mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d) begin
      redirect_pc_d = ex_taken ? ex_target : ex_pcplus4;
    end
    flush_d = (state_d == BRC_FLUSH);
  end

  // Saturating statistics: they stick at all-ones instead of wrapping.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    drop_cnt_d       = drop_cnt_q;
    if (accept && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (accept && mispredict && (mispredict_cnt_q != '1)) begin
      mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Output and statistics registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      drop_cnt_q       <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush_fd       = flush_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for the branch resolve controller with hand-computed
// expected values for redirects, flush timing, queueing and statistics.
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pcplus4;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_fd;
  logic        stall_pipe;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(
    .WORD_SIZE    (32),
    .QDEPTH       (4),
    .FLUSH_CYCLES (2),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pcplus4     (ex_pcplus4),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_fd       (flush_fd),
    .stall_pipe     (stall_pipe),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt),
    .drop_cnt       (drop_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic tk,
                               input logic [31:0] tgt, input logic [31:0] p4,
                               input logic ptk, input logic [31:0] ptgt, input logic rdy);
    ex_valid       = v;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pcplus4     = p4;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    upd_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Correct, taken branch whose target matches the prediction.
  task automatic goodBranch(input logic [31:0] pc, input logic rdy);
    applyStimulus(1'b1, pc, 1'b1, pc + 32'h100, pc + 32'h4, 1'b1, pc + 32'h100, rdy);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0);
    #2 rst = 1'b0;
    #10;
    checkOutput("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
    checkOutput("rst_flush", {31'b0, flush_fd}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall_pipe}, 32'd0);
    checkOutput("rst_upd_valid", {31'b0, upd_valid}, 32'd0);
    checkOutput("rst_upd_pc", upd_pc, 32'd0);
    checkOutput("rst_branch_cnt", {16'b0, branch_cnt}, 32'd0);
    rst = 1'b1;

    // Correct prediction, both targets 0x40.
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h40, 32'h104, 1'b1, 32'h40, 1'b0);
    tick();
    checkOutput("ok_redirect", {31'b0, redirect_valid}, 32'd0);
    checkOutput("ok_flush", {31'b0, flush_fd}, 32'd0);
    checkOutput("ok_upd_valid", {31'b0, upd_valid}, 32'd1);
    checkOutput("ok_upd_pc", upd_pc, 32'h100);
    checkOutput("ok_upd_target", upd_target, 32'h40);
    checkOutput("ok_upd_taken", {31'b0, upd_taken}, 32'd1);
    checkOutput("ok_branch_cnt", {16'b0, branch_cnt}, 32'd1);
    checkOutput("ok_mp_cnt", {16'b0, mispredict_cnt}, 32'd0);
    idle(1'b1);
    tick();
    checkOutput("ok_drained", {31'b0, upd_valid}, 32'd0);

    // Direction mispredict: predicted not taken, actually taken to 0x80.
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h80, 32'h14, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("dir_redirect_valid", {31'b0, redirect_valid}, 32'd1);
    checkOutput("dir_redirect_pc", redirect_pc, 32'h80);
    checkOutput("dir_flush1", {31'b0, flush_fd}, 32'd1);
    checkOutput("dir_mp_cnt", {16'b0, mispredict_cnt}, 32'd1);
    checkOutput("dir_branch_cnt", {16'b0, branch_cnt}, 32'd2);
    checkOutput("dir_upd_pc", upd_pc, 32'h10);
    // Wrong-path resolution during FLUSH must be ignored.
    applyStimulus(1'b1, 32'h20, 1'b0, 32'h90, 32'h24, 1'b1, 32'h90, 1'b1);
    tick();
    checkOutput("sq_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    checkOutput("sq_flush2", {31'b0, flush_fd}, 32'd1);
    checkOutput("sq_branch_cnt", {16'b0, branch_cnt}, 32'd2);
    checkOutput("sq_mp_cnt", {16'b0, mispredict_cnt}, 32'd1);
    checkOutput("sq_upd_valid", {31'b0, upd_valid}, 32'd0);
    idle(1'b1);
    tick();
    checkOutput("dir_flush_end", {31'b0, flush_fd}, 32'd0);

    // Not-taken mispredict redirects to the fall-through PC.
    applyStimulus(1'b1, 32'h30, 1'b0, 32'h99, 32'h34, 1'b1, 32'h99, 1'b1);
    tick();
    checkOutput("nt_redirect_pc", redirect_pc, 32'h34);
    checkOutput("nt_redirect_valid", {31'b0, redirect_valid}, 32'd1);
    checkOutput("nt_mp_cnt", {16'b0, mispredict_cnt}, 32'd2);
    idle(1'b1);
    tick();
    checkOutput("nt_redirect_pulse", {31'b0, redirect_valid}, 32'd0);
    tick();

    // Target mispredict: both taken, targets differ.
    applyStimulus(1'b1, 32'h50, 1'b1, 32'h60, 32'h54, 1'b1, 32'h64, 1'b1);
    tick();
    checkOutput("tgt_redirect_pc", redirect_pc, 32'h60);
    checkOutput("tgt_mp_cnt", {16'b0, mispredict_cnt}, 32'd3);
    checkOutput("tgt_branch_cnt", {16'b0, branch_cnt}, 32'd4);
    idle(1'b1);
    tick();
    // Last flush cycle: still wrong path.
    goodBranch(32'h70, 1'b1);
    tick();
    checkOutput("edge_ignored_cnt", {16'b0, branch_cnt}, 32'd4);
    checkOutput("edge_flush_off", {31'b0, flush_fd}, 32'd0);
    // First cycle after the flush window is accepted.
    applyStimulus(1'b1, 32'h74, 1'b0, 32'h200, 32'h78, 1'b0, 32'h200, 1'b1);
    tick();
    checkOutput("edge_accept_cnt", {16'b0, branch_cnt}, 32'd5);
    checkOutput("edge_upd_pc", upd_pc, 32'h74);
    checkOutput("edge_upd_taken", {31'b0, upd_taken}, 32'd0);
    checkOutput("edge_no_redirect", {31'b0, redirect_valid}, 32'd0);
    idle(1'b1);
    tick();
    checkOutput("edge_drained", {31'b0, upd_valid}, 32'd0);

    // Backpressure: five branches with upd_ready low.
    for (int i = 0; i < 5; i++) begin
      goodBranch(32'h200 + 32'(i * 4), 1'b0);
      tick();
      if (i == 1) checkOutput("bp_stall_after2", {31'b0, stall_pipe}, 32'd0);
      if (i == 2) checkOutput("bp_stall_after3", {31'b0, stall_pipe}, 32'd1);
    end
    checkOutput("bp_drop_cnt", {16'b0, drop_cnt}, 32'd1);
    checkOutput("bp_branch_cnt", {16'b0, branch_cnt}, 32'd10);
    checkOutput("bp_head_held", upd_pc, 32'h200);
    idle(1'b1);
    checkOutput("bp_drain0", upd_pc, 32'h200);
    tick();
    checkOutput("bp_drain1", upd_pc, 32'h204);
    checkOutput("bp_stall_occ3", {31'b0, stall_pipe}, 32'd1);
    tick();
    checkOutput("bp_drain2", upd_pc, 32'h208);
    checkOutput("bp_stall_occ2", {31'b0, stall_pipe}, 32'd0);
    tick();
    checkOutput("bp_drain3", upd_pc, 32'h20C);
    checkOutput("bp_drain3_tgt", upd_target, 32'h30C);
    tick();
    checkOutput("bp_drained", {31'b0, upd_valid}, 32'd0);

    // Full queue with a same-cycle pop accepts the new entry.
    for (int i = 0; i < 4; i++) begin
      goodBranch(32'h300 + 32'(i * 4), 1'b0);
      tick();
    end
    checkOutput("fp_stall_full", {31'b0, stall_pipe}, 32'd1);
    goodBranch(32'h310, 1'b1);
    tick();
    checkOutput("fp_drop_cnt", {16'b0, drop_cnt}, 32'd1);
    checkOutput("fp_branch_cnt", {16'b0, branch_cnt}, 32'd15);
    checkOutput("fp_head", upd_pc, 32'h304);
    idle(1'b1);
    tick();
    checkOutput("fp_head2", upd_pc, 32'h308);
    tick();
    checkOutput("fp_head3", upd_pc, 32'h30C);
    tick();
    checkOutput("fp_head4", upd_pc, 32'h310);
    tick();
    checkOutput("fp_drained", {31'b0, upd_valid}, 32'd0);

    // Reset in the middle of FLUSH with two queued entries.
    goodBranch(32'h400, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h404, 1'b1, 32'h500, 32'h408, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("mr_flush_pre", {31'b0, flush_fd}, 32'd1);
    checkOutput("mr_mp_pre", {16'b0, mispredict_cnt}, 32'd4);
    checkOutput("mr_head_pre", upd_pc, 32'h400);
    idle(1'b0);
    rst = 1'b0;
    #2;
    checkOutput("mr_flush", {31'b0, flush_fd}, 32'd0);
    checkOutput("mr_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    checkOutput("mr_redirect_pc", redirect_pc, 32'd0);
    checkOutput("mr_upd_valid", {31'b0, upd_valid}, 32'd0);
    checkOutput("mr_upd_pc", upd_pc, 32'd0);
    checkOutput("mr_branch_cnt", {16'b0, branch_cnt}, 32'd0);
    checkOutput("mr_mp_cnt", {16'b0, mispredict_cnt}, 32'd0);
    checkOutput("mr_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    #2 rst = 1'b1;
    tick();
    checkOutput("mr_post_empty", {31'b0, upd_valid}, 32'd0);
    checkOutput("mr_post_flush", {31'b0, flush_fd}, 32'd0);
    goodBranch(32'h600, 1'b0);
    tick();
    checkOutput("mr_post_upd_pc", upd_pc, 32'h600);
    checkOutput("mr_post_branch_cnt", {16'b0, branch_cnt}, 32'd1);
    idle(1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
